// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and oversampling ratio.
// Kept generic so a matching TX framer can import the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;
    localparam int OVERSAMPLE = 16;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every CLOCK_FRQ/(16*BADRATE) clocks.
// restart re-phases the divider so tick timing is relative to the detected start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLOCK_FRQ = 100_000_000,
    parameter int BADRATE   = 115_200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int RAW_DIV  = CLOCK_FRQ / (OVERSAMPLE * BADRATE);
    localparam int TICK_DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = w_wrap && !restart;

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x-oversampled UART receiver: synchronises rxd, majority-votes ticks 7/8/9 of each bit and
// emits one-cycle byte / framing-error / parity-error strobes with stuck-low recovery.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLOCK_FRQ = 100_000_000,
    parameter int BADRATE   = 115_200,
    parameter int UART_BIT  = 8,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    if (CLOCK_FRQ < OVERSAMPLE * BADRATE) begin : g_bad_rate
        $error("uart_rx_deframer: CLOCK_FRQ must be at least 16*BADRATE");
    end
    if (UART_BIT < 5 || UART_BIT > 8) begin : g_bad_width
        $error("uart_rx_deframer: UART_BIT must be 5..8");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_deframer: PARITY must be 0, 1 or 2");
    end

    localparam logic [2:0] LAST_BIT = 3'(UART_BIT - 1);

    logic       r_sync1, r_sync2, r_rx_d;
    rx_state_t  r_state;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_high_cnt;
    logic       r_s7, r_s8;
    logic [7:0] r_shift;
    logic       r_par_err;
    logic       r_start_ok;
    logic [7:0] r_data;
    logic       r_valid, r_ferr, r_perr;

    logic       w_tick, w_fall, w_restart, w_decide, w_bit_end, w_maj, w_par_exp;
    logic [7:0] w_shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
        end
    end

    assign w_fall    = r_rx_d & ~r_sync2;
    assign w_restart = (r_state == RX_IDLE) && w_fall;

    uart_baud_tick #(
        .CLOCK_FRQ (CLOCK_FRQ),
        .BADRATE   (BADRATE)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Third vote is the live synchronised level at the tick-9 decision.
    assign w_decide     = w_tick && (r_tick_cnt == 4'd9);
    assign w_bit_end    = w_tick && (r_tick_cnt == 4'd15);
    assign w_maj        = majority3(r_s7, r_s8, r_sync2);
    assign w_par_exp    = (^r_shift) ^ (PARITY == PAR_ODD);
    assign w_shift_next = {1'b0, r_shift[7:1]} | (8'(w_maj) << (UART_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RX_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_high_cnt <= '0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_start_ok <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
                if (r_tick_cnt == 4'd7) r_s7 <= r_sync2;
                if (r_tick_cnt == 4'd8) r_s8 <= r_sync2;
            end
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state    <= RX_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_shift    <= '0;
                        r_par_err  <= 1'b0;
                        r_start_ok <= 1'b0;
                    end
                end
                RX_START: begin
                    if (w_decide) begin
                        if (w_maj) r_state <= RX_IDLE;
                        else       r_start_ok <= 1'b1;
                    end else if (w_bit_end) begin
                        r_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_decide) begin
                        r_shift <= w_shift_next;
                    end else if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_decide)       r_par_err <= (w_maj != w_par_exp);
                    else if (w_bit_end) r_state   <= RX_STOP;
                end
                RX_STOP: begin
                    // Leaving at mid-stop lets a zero-gap next start bit be caught.
                    if (w_decide) begin
                        if (!w_maj) begin
                            r_ferr     <= 1'b1;
                            r_high_cnt <= '0;
                            r_state    <= RX_WAIT_IDLE;
                        end else if (r_par_err) begin
                            r_perr  <= 1'b1;
                            r_state <= RX_IDLE;
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                            r_state <= RX_IDLE;
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    if (w_tick) begin
                        if (!r_sync2)                   r_high_cnt <= '0;
                        else if (r_high_cnt == 4'd15)   r_state    <= RX_IDLE;
                        else                            r_high_cnt <= r_high_cnt + 4'd1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data_byte = r_data;
    assign rx_valid     = r_valid;
    assign frame_err    = r_ferr;
    assign parity_err   = r_perr;
    assign rx_busy      = (r_state != RX_IDLE) && !((r_state == RX_START) && !r_start_ok);

endmodule
